mux_arb_nto1: RTL

MUX_ARB_NTO1 -- requirements
Module: mux_arb_nto1

---
 rtl/mux_pkg.sv | 26 ++
 rtl/rr_pick.sv | 38 +++
 rtl/mux_arb_nto1.sv | 108 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants and elaboration helpers for the N-to-1 arbitrating mux.
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A single-bit select is kept even for degenerate channel counts.
  function automatic int sel_width(input int n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first valid channel at or after ptr, wrapping at NCH.
// Purely combinational; found=0 when no channel is valid.
module rr_pick #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  in_valid,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] index,
  output logic            found
);

  // One spare bit so ptr+off never overflows before the explicit wrap.
  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base,
                                               input int unsigned     off);
    logic [SELW:0] s;
    s = {1'b0, base} + (SELW+1)'(off);
    if (s >= (SELW+1)'(NCH)) s = s - (SELW+1)'(NCH);
    return s[SELW-1:0];
  endfunction

  logic [SELW-1:0] cand;

  // Scan from the farthest offset down so the nearest valid channel wins last.
  always_comb begin
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = wrap_add(ptr, int'(k));
      if (in_valid[cand]) begin
        index = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 mux with select-driven or round-robin arbitration into a single
// output register; one-cycle latency, full throughput, holds under backpressure.
module mux_arb_nto1
  import mux_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NCH   = 4,
  parameter  int MODE  = 0,
  localparam int SELW  = sel_width(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      grant
);

  localparam int VW = 1 << SELW;

  out_state_e      state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  grant_q, grant_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en;
  logic             xfer;
  logic             cand_ok;
  logic [SELW-1:0]  cand_idx;
  logic [WIDTH-1:0] cand_data;

  if (MODE == MODE_RR) begin : g_rr
    rr_pick #(
      .NCH  (NCH),
      .SELW (SELW)
    ) u_rr_pick (
      .in_valid (in_valid),
      .ptr      (ptr_q),
      .index    (cand_idx),
      .found    (cand_ok)
    );
    logic unused_sel;
    assign unused_sel = ^sel;
  end else begin : g_sel
    // Zero padding makes out-of-range selects read as "not valid".
    logic [VW-1:0] valid_pad;
    assign valid_pad = VW'(in_valid);
    assign cand_idx  = sel;
    assign cand_ok   = valid_pad[sel];
  end

  always_comb begin
    cand_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cand_idx == SELW'(i)) cand_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // rst_n gates xfer so in_ready stays low throughout reset.
  assign load_en = (state_q == ST_EMPTY) || out_ready;
  assign xfer    = rst_n && load_en && cand_ok;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = xfer && (cand_idx == SELW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    if (xfer) begin
      state_d    = ST_FULL;
      out_data_d = cand_data;
      grant_d    = cand_idx;
      if (MODE == MODE_RR) begin
        ptr_d = (cand_idx == SELW'(NCH - 1)) ? '0 : cand_idx + SELW'(1);
      end
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      grant_q    <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign grant     = grant_q;

endmodule
